// File: rtl/vga_fb_fetch_arbiter.sv
// Frame-buffer port arbiter: keeps the VGA pixel FIFO topped up with fixed-length
// read bursts and slots single host writes into the idle gaps between bursts.
module vga_fb_fetch_arbiter #(
  parameter int PIX_W      = 24,
  parameter int ADDR_W     = 19,
  parameter int FRAME_PIX  = 307200,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LOW_WM     = 32,
  parameter int RD_LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_sync,
  input  logic [6:0]        fifo_level,
  output logic              fifo_wreq,
  output logic [PIX_W-1:0]  fifo_wdata,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [PIX_W-1:0]  host_wdata,
  output logic              host_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic              busy_disp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_HOST  = 2'd2
  } state_t;

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam int INF_W = $clog2(BURST_LEN + RD_LAT + 1);
  localparam logic [7:0]        WM_8      = 8'(LOW_WM);
  localparam logic [7:0]        BL_8      = 8'(BURST_LEN);
  localparam logic [7:0]        DEPTH_8   = 8'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(BURST_LEN);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, fetch_next;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic              sync_pend_q, sync_pend_d;
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [PIX_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic              host_ack_q, host_ack_d;
  logic              busy_disp_q, busy_disp_d;
  logic [7:0]        occ;
  logic              need, room, rd_issue;

  // A read is "issued" in the cycle its strobe is on the bus.
  assign rd_issue  = mem_en_q & ~mem_we_q;
  assign fifo_wreq = rd_vld_q[RD_LAT-1];
  assign fifo_wdata = fifo_wreq ? mem_rdata : '0;
  assign host_ack  = host_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy_disp = busy_disp_q;

  always_comb begin
    occ        = 8'(fifo_level) + 8'(inflight_q);
    need       = occ < WM_8;
    room       = (occ + BL_8) <= DEPTH_8;
    fetch_next = (fetch_addr_q == LAST_ADDR) ? '0 : fetch_addr_q + 1'b1;
    rd_vld_d   = (rd_vld_q << 1) | RD_LAT'(rd_issue);
    inflight_d = inflight_q + INF_W'(rd_issue) - INF_W'(fifo_wreq);

    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    burst_cnt_d  = burst_cnt_q;
    sync_pend_d  = sync_pend_q | frame_sync;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    host_ack_d   = 1'b0;
    busy_disp_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A pending frame restart consumes this idle cycle; a new pulse re-arms it.
        if (sync_pend_q) begin
          fetch_addr_d = '0;
          sync_pend_d  = frame_sync;
        end else if (need && room) begin
          state_d      = S_BURST;
          mem_en_d     = 1'b1;
          mem_addr_d   = fetch_addr_q;
          fetch_addr_d = fetch_next;
          burst_cnt_d  = CNT_W'(1);
          busy_disp_d  = 1'b1;
        end else if (host_req) begin
          state_d     = S_HOST;
          mem_en_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = host_addr;
          mem_wdata_d = host_wdata;
          host_ack_d  = 1'b1;
        end
      end
      S_BURST: begin
        if (burst_cnt_q == LAST_CNT) begin
          state_d = S_IDLE;
        end else begin
          mem_en_d     = 1'b1;
          mem_addr_d   = fetch_addr_q;
          fetch_addr_d = fetch_next;
          burst_cnt_d  = burst_cnt_q + 1'b1;
          busy_disp_d  = 1'b1;
        end
      end
      S_HOST: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Reset also flushes the return pipeline so aborted reads never reach the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_addr_q <= '0;
      burst_cnt_q  <= '0;
      inflight_q   <= '0;
      sync_pend_q  <= 1'b0;
      rd_vld_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      host_ack_q   <= 1'b0;
      busy_disp_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      burst_cnt_q  <= burst_cnt_d;
      inflight_q   <= inflight_d;
      sync_pend_q  <= sync_pend_d;
      rd_vld_q     <= rd_vld_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      host_ack_q   <= host_ack_d;
      busy_disp_q  <= busy_disp_d;
    end
  end

endmodule

// File: tb/tb_vga_fb_fetch_arbiter.sv
// Bench for vga_fb_fetch_arbiter: decision vectors, directed multi-cycle sequences
// and random traffic, all checked against a transaction-level access schedule.
module tb_vga_fb_fetch_arbiter;
  localparam int PIX_W  = 24;
  localparam int ADDR_W = 19;
  localparam int FRAME  = 37;   // short frame so address wrap is reachable quickly
  localparam int BLEN   = 16;
  localparam int DEPTH  = 64;
  localparam int LWM    = 32;
  localparam int RDL    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_sync = 1'b0;
  logic [6:0]        fifo_level = '0;
  logic              fifo_wreq;
  logic [PIX_W-1:0]  fifo_wdata;
  logic              host_req = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [PIX_W-1:0]  host_wdata = '0;
  logic              host_ack;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata = '0;
  logic              busy_disp;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  vga_fb_fetch_arbiter #(
    .PIX_W(PIX_W), .ADDR_W(ADDR_W), .FRAME_PIX(FRAME), .BURST_LEN(BLEN),
    .FIFO_DEPTH(DEPTH), .LOW_WM(LWM), .RD_LAT(RDL)
  ) dut (
    .clk(clk), .rst(rst), .frame_sync(frame_sync), .fifo_level(fifo_level),
    .fifo_wreq(fifo_wreq), .fifo_wdata(fifo_wdata), .host_req(host_req),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ack(host_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy_disp(busy_disp)
  );

  typedef enum logic [1:0] {K_NONE, K_RD, K_WR} kind_e;

  typedef struct {
    int                lvl;
    logic              hreq;
    logic [ADDR_W-1:0] haddr;
    logic [PIX_W-1:0]  hdata;
    logic              en;
    logic              we;
    logic              ack;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  wd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // stimulus state
  int                hold_lvl = -1;
  int                fill = 0;
  bit                host_busy = 0;
  logic [ADDR_W-1:0] h_addr = '0;
  logic [PIX_W-1:0]  h_data = '0;
  bit                sync_now = 0;
  bit                rand_on = 0;

  // reference schedule: access expected on the bus in the current cycle
  kind_e             m_cur = K_NONE;
  int                m_run = 0;
  int                m_fetch = 0;
  bit                m_pend = 0;
  int                m_raddr = 0;
  logic [ADDR_W-1:0] m_waddr = '0;
  logic [PIX_W-1:0]  m_wdata = '0;
  int                m_iss = 0;
  int                m_ret = 0;
  int                infl_now = 0;
  logic [PIX_W-1:0]  exp_q[$];
  int                due_q[$];

  // memory model (tracks the reads the DUT actually issued)
  bit                rdv[2];
  logic [ADDR_W-1:0] rda[2];

  // observation counters for directed sequences
  int n_rd = 0, n_ack = 0, n_wreq = 0, ack_cyc = -1, first_wreq = -1;

  function automatic logic [PIX_W-1:0] pix_of(int a);
    logic [31:0] h;
    h = 32'(a) * 32'h9E37_79B1 + 32'h0012_3457;
    return h[31:8];
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Choose the inputs for the current cycle, then predict the next cycle's access.
  task automatic plan();
    kind_e nxt;
    int    occ;
    if (rand_on) begin
      if (fill > 0 && $urandom_range(0, 2) != 0) fill--;
      if ($urandom_range(0, 63) == 0) fill = $urandom_range(0, 100);
      if (!host_busy && $urandom_range(0, 7) == 0) begin
        host_busy = 1;
        h_addr    = ADDR_W'($urandom());
        h_data    = PIX_W'($urandom());
      end
      if ($urandom_range(0, 49) == 0) sync_now = 1;
    end
    fifo_level = (hold_lvl >= 0) ? 7'(hold_lvl) : 7'(fill);
    host_req   = host_busy;
    host_addr  = h_addr;
    host_wdata = h_data;
    frame_sync = sync_now;
    sync_now   = 0;

    occ = int'(fifo_level) + infl_now;
    if (m_cur == K_RD && m_run < BLEN) nxt = K_RD;
    else if (m_cur != K_NONE) nxt = K_NONE;
    else if (m_pend) begin
      nxt     = K_NONE;
      m_pend  = 0;
      m_fetch = 0;
    end
    else if (occ < LWM && occ + BLEN <= DEPTH) nxt = K_RD;
    else if (host_req) nxt = K_WR;
    else nxt = K_NONE;
    if (frame_sync) m_pend = 1;

    if (nxt == K_RD) begin
      m_run   = (m_cur == K_RD) ? m_run + 1 : 1;
      m_raddr = m_fetch;
      m_fetch = (m_fetch + 1) % FRAME;
      exp_q.push_back(pix_of(m_raddr));
      due_q.push_back(cyc + 1 + RDL);
    end else begin
      m_run = 0;
    end
    if (nxt == K_WR) begin
      m_waddr = host_addr;
      m_wdata = host_wdata;
    end
    m_cur = nxt;
  endtask

  // Advance one clock, check this cycle's outputs against the schedule, then plan.
  task automatic step();
    bit               exp_wreq;
    logic [PIX_W-1:0] e;
    @(negedge clk);
    cyc++;
    mem_rdata = rdv[1] ? pix_of(int'(rda[1])) : PIX_W'($urandom());
    #1;
    exp_wreq = (due_q.size() > 0) && (due_q[0] == cyc);
    check("bus", 64'({mem_en, mem_we, host_ack, busy_disp, fifo_wreq}),
          64'({m_cur != K_NONE, m_cur == K_WR, m_cur == K_WR, m_cur == K_RD, exp_wreq}));
    if (m_cur == K_RD) check("rd_addr", 64'(mem_addr), 64'(m_raddr));
    if (m_cur == K_WR) begin
      check("wr_addr", 64'(mem_addr), 64'(m_waddr));
      check("wr_data", 64'(mem_wdata), 64'(m_wdata));
    end
    if (exp_wreq) begin
      e = exp_q.pop_front();
      void'(due_q.pop_front());
      check("pix", 64'(fifo_wdata), 64'(e));
    end
    infl_now = m_iss - m_ret;
    m_iss += (m_cur == K_RD) ? 1 : 0;
    m_ret += exp_wreq ? 1 : 0;

    rdv[1] = rdv[0];
    rda[1] = rda[0];
    rdv[0] = mem_en && !mem_we;
    rda[0] = mem_addr;

    if (mem_en && !mem_we) n_rd++;
    if (host_ack) begin
      n_ack++;
      ack_cyc = cyc;
    end
    if (fifo_wreq) begin
      n_wreq++;
      if (first_wreq < 0) first_wreq = cyc;
      if (fill < 127) fill++;
    end
    if (m_cur == K_WR) host_busy = 0;
    plan();
  endtask

  // Assert reset (at a falling edge, or mid-cycle when mid=1), check outputs, release.
  task automatic do_reset(int lvl, int fill0, bit mid);
    if (mid) begin
      @(posedge clk);
      #2;
    end else begin
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("rst_ctrl", 64'({fifo_wreq, host_ack, mem_en, mem_we, busy_disp}), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_data", 64'({fifo_wdata, mem_wdata}), 64'd0);
    host_req = 1'b0; frame_sync = 1'b0; host_busy = 0; sync_now = 0;
    exp_q.delete(); due_q.delete();
    m_cur = K_NONE; m_run = 0; m_fetch = 0; m_pend = 0;
    m_iss = 0; m_ret = 0; infl_now = 0;
    rdv[0] = 0; rdv[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0; hold_lvl = lvl; fill = fill0;
    n_rd = 0; n_ack = 0; n_wreq = 0; ack_cyc = -1; first_wreq = -1;
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];

  initial begin
    vecs[0] = '{0,   1'b0, 19'h0,     24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 19'h0,     24'h0};
    vecs[1] = '{31,  1'b1, 19'h55,    24'h123456, 1'b1, 1'b0, 1'b0, 1'b1, 19'h0,     24'h0};
    vecs[2] = '{32,  1'b1, 19'h100,   24'hFF00FF, 1'b1, 1'b1, 1'b1, 1'b0, 19'h100,   24'hFF00FF};
    vecs[3] = '{40,  1'b0, 19'h0,     24'h0,      1'b0, 1'b0, 1'b0, 1'b0, 19'h0,     24'h0};
    vecs[4] = '{127, 1'b1, 19'h7FFFF, 24'hABCDEF, 1'b1, 1'b1, 1'b1, 1'b0, 19'h7FFFF, 24'hABCDEF};
    vecs[5] = '{30,  1'b0, 19'h0,     24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 19'h0,     24'h0};

    // single decisions from a clean reset
    for (int i = 0; i < 6; i++) begin
      do_reset(vecs[i].lvl, 0, 1'b0);
      host_busy = vecs[i].hreq;
      h_addr    = vecs[i].haddr;
      h_data    = vecs[i].hdata;
      plan();
      step();
      check("vec_ctrl", 64'({mem_en, mem_we, host_ack, busy_disp}),
            64'({vecs[i].en, vecs[i].we, vecs[i].ack, vecs[i].busy}));
      if (vecs[i].en) check("vec_addr", 64'(mem_addr), 64'(vecs[i].addr));
      if (vecs[i].we) check("vec_wdata", 64'(mem_wdata), 64'(vecs[i].wd));
    end

    // empty FIFO that fills from returns: bursts until the watermark is reached
    do_reset(-1, 0, 1'b0);
    plan();
    repeat (18) step();
    check("first_wreq_cycle", 64'(first_wreq), 64'd3);
    check("wreq_first_burst", 64'(n_wreq), 64'd16);
    repeat (42) step();
    check("reads_until_full", 64'(n_rd), 64'd32);

    // level above watermark: host write goes straight through
    do_reset(40, 0, 1'b0);
    host_busy = 1; h_addr = 19'h100; h_data = 24'hFF00FF;
    plan();
    repeat (6) step();
    check("host_only_acks", 64'(n_ack), 64'd1);
    check("host_only_reads", 64'(n_rd), 64'd0);

    // display wins over a simultaneous host request
    do_reset(-1, 20, 1'b0);
    host_busy = 1; h_addr = 19'h2A; h_data = 24'h0F0F0F;
    plan();
    repeat (25) step();
    check("host_after_burst_cycle", 64'(ack_cyc), 64'd18);
    check("host_after_burst_acks", 64'(n_ack), 64'd1);

    // fetch address wraps inside a burst with no gap
    do_reset(0, 0, 1'b0);
    plan();
    while (cyc < 39) step();
    check("wrap_last", 64'(mem_addr), 64'(FRAME - 1));
    step();
    check("wrap_zero", 64'({mem_en, mem_addr}), 64'({1'b1, 19'd0}));

    // frame_sync on the 5th read: burst finishes, next burst restarts at 0
    do_reset(0, 0, 1'b0);
    plan();
    while (cyc < 4) step();
    sync_now = 1;
    step();
    while (cyc < 16) step();
    check("sync_burst_tail", 64'(mem_addr), 64'd15);
    repeat (2) step();
    check("sync_idle_gap", 64'(mem_en), 64'd0);
    step();
    check("sync_restart", 64'({mem_en, mem_addr}), 64'({1'b1, 19'd0}));

    // reset mid-burst with reads in flight: nothing returns afterwards
    do_reset(0, 0, 1'b0);
    plan();
    while (cyc < 5) step();
    do_reset(40, 0, 1'b1);
    plan();
    repeat (10) step();
    check("no_stale_wreq", 64'(n_wreq), 64'd0);
    hold_lvl = 0;
    repeat (20) step();

    // random traffic against the schedule
    do_reset(-1, 0, 1'b0);
    rand_on = 1;
    plan();
    repeat (3000) step();
    rand_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
